// File: rtl/recorder_pkg.sv
// Shared types and default sizing for the recorder channel controller.
package recorder_pkg;

  localparam int DEFAULT_ADDR_W          = 17;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } rec_state_t;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, one-cycle press pulse.
module button_debounce
  import recorder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic [1:0]       r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;
  logic             w_differ;
  logic             w_expire;

  assign w_differ = r_sync[1] ^ r_level;
  assign w_expire = w_differ && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  // NOTE: non-blocking assignments make the synchronizer stages shift one per
  // clock; blocking ones would collapse both stages into a single flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_press <= w_expire & ~r_level;
      if (!w_differ || w_expire) r_cnt <= '0;
      else                       r_cnt <= r_cnt + CNT_W'(1);
      if (w_expire) r_level <= ~r_level;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/recorder_chan_ctrl.sv
// Channel select and record/playback sequencer over a two-half sample memory.
// Define LOOP_PLAY_EN to make playback wrap to the start instead of stopping.
module recorder_chan_ctrl
  import recorder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int ADDR_W          = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_chan,
  input  logic              btn_rec,
  input  logic              btn_play,
  input  logic              sample_tick,
  output logic              num,
  output logic              rec_en,
  output logic              play_en,
  output logic              mem_we,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr
);

  localparam int              OFF_W   = ADDR_W - 1;
  localparam logic [OFF_W-1:0] OFF_MAX = '1;

  logic w_press_chan;
  logic w_press_rec;
  logic w_press_play;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_chan (
    .clk(clk), .rst(rst), .i_btn(btn_chan), .o_press(w_press_chan)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rec (
    .clk(clk), .rst(rst), .i_btn(btn_rec), .o_press(w_press_rec)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_play (
    .clk(clk), .rst(rst), .i_btn(btn_play), .o_press(w_press_play)
  );

  rec_state_t        r_state;
  logic              r_num;
  logic [OFF_W-1:0]  r_offset;
  logic [ADDR_W-1:0] r_rec_len [2];
  logic              r_rec_en;
  logic              r_play_en;

  rec_state_t        w_state_nxt;
  logic              w_num_nxt;
  logic [OFF_W-1:0]  w_offset_nxt;
  logic              w_len_we;
  logic [ADDR_W-1:0] w_len_val;
  logic [ADDR_W-1:0] w_cur_len;

  assign w_cur_len = r_rec_len[r_num];

  // NOTE: every output of this block gets a default first, so no branch can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_num_nxt    = r_num;
    w_offset_nxt = r_offset;
    w_len_we     = 1'b0;
    w_len_val    = {1'b0, r_offset} + ADDR_W'(sample_tick);
    case (r_state)
      IDLE: begin
        if (w_press_rec) begin
          w_state_nxt  = RECORD;
          w_offset_nxt = '0;
        end else if (w_press_play) begin
          if (w_cur_len != '0) begin
            w_state_nxt  = PLAY;
            w_offset_nxt = '0;
          end
        end else if (w_press_chan) begin
          w_num_nxt = ~r_num;
        end
      end
      RECORD: begin
        // A stop press coinciding with a tick still keeps that sample.
        if (w_press_rec || (sample_tick && r_offset == OFF_MAX)) begin
          w_len_we     = 1'b1;
          w_state_nxt  = IDLE;
          w_offset_nxt = '0;
        end else if (sample_tick) begin
          w_offset_nxt = r_offset + OFF_W'(1);
        end
      end
      PLAY: begin
        if (w_press_play) begin
          w_state_nxt  = IDLE;
          w_offset_nxt = '0;
        end else if (sample_tick) begin
          if ({1'b0, r_offset} == w_cur_len - ADDR_W'(1)) begin
            w_offset_nxt = '0;
`ifdef LOOP_PLAY_EN
            w_state_nxt  = PLAY;
`else
            w_state_nxt  = IDLE;
`endif
          end else begin
            w_offset_nxt = r_offset + OFF_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_offset_nxt = '0;
      end
    endcase
  end

  // NOTE: the two length words are reset on purpose: the play gate reads them,
  // and a reset is meant to discard whatever was recorded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_num        <= 1'b0;
      r_offset     <= '0;
      r_rec_len[0] <= '0;
      r_rec_len[1] <= '0;
      r_rec_en     <= 1'b0;
      r_play_en    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_num     <= w_num_nxt;
      r_offset  <= w_offset_nxt;
      r_rec_en  <= (w_state_nxt == RECORD);
      r_play_en <= (w_state_nxt == PLAY);
      if (w_len_we) r_rec_len[r_num] <= w_len_val;
    end
  end

  assign num      = r_num;
  assign rec_en   = r_rec_en;
  assign play_en  = r_play_en;
  assign mem_we   = (r_state == RECORD) & sample_tick;
  assign mem_rd   = (r_state == PLAY) & sample_tick;
  assign mem_addr = {r_num, r_offset};

endmodule

// File: tb/tb_recorder_chan_ctrl.sv
// Self-checking bench for recorder_chan_ctrl: behavioural model plus directed and random stimulus.
module tb_recorder_chan_ctrl;

  localparam int DC   = 4;
  localparam int AW   = 4;
  localparam int HALF = 1 << (AW - 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn_chan = 1'b0;
  logic          btn_rec = 1'b0;
  logic          btn_play = 1'b0;
  logic          sample_tick = 1'b0;
  logic          num;
  logic          rec_en;
  logic          play_en;
  logic          mem_we;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;

  recorder_chan_ctrl #(.DEBOUNCE_CYCLES(DC), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .btn_chan(btn_chan), .btn_rec(btn_rec),
    .btn_play(btn_play), .sample_tick(sample_tick), .num(num),
    .rec_en(rec_en), .play_en(play_en), .mem_we(mem_we), .mem_rd(mem_rd),
    .mem_addr(mem_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;
  logic [AW-1:0] wr_log[$];
  logic [AW-1:0] rd_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. Button index: 0 chan, 1 rec, 2 play. Mode: 0 idle, 1 record, 2 play.
  int m_s1[3], m_s2[3], m_lvl[3], m_run[3], m_prs[3];
  int m_mode, m_ch, m_off;
  int m_len[2];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_prs[i] = 0;
    end
    m_mode = 0; m_ch = 0; m_off = 0; m_len[0] = 0; m_len[1] = 0;
  endtask

  task automatic model_step();
    int p[3];
    int raw[3];
    int written;
    if (rst) begin
      model_reset();
      return;
    end
    raw[0] = int'(btn_chan); raw[1] = int'(btn_rec); raw[2] = int'(btn_play);
    for (int i = 0; i < 3; i++) p[i] = m_prs[i];
    case (m_mode)
      0: begin
        if (p[1] != 0) begin
          m_mode = 1; m_off = 0;
        end else if (p[2] != 0) begin
          if (m_len[m_ch] != 0) begin m_mode = 2; m_off = 0; end
        end else if (p[0] != 0) begin
          m_ch = 1 - m_ch;
        end
      end
      1: begin
        written = m_off + (sample_tick ? 1 : 0);
        if (p[1] != 0 || (sample_tick && m_off == HALF - 1)) begin
          m_len[m_ch] = written; m_mode = 0; m_off = 0;
        end else begin
          m_off = written;
        end
      end
      default: begin
        if (p[2] != 0) begin
          m_mode = 0; m_off = 0;
        end else if (sample_tick) begin
          m_off++;
          if (m_off == m_len[m_ch]) begin
            m_off = 0;
`ifndef LOOP_PLAY_EN
            m_mode = 0;
`endif
          end
        end
      end
    endcase
    // A synced level is accepted after DC consecutive cycles of disagreement.
    for (int i = 0; i < 3; i++) begin
      m_prs[i] = 0;
      if (m_s2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DC) begin
          m_lvl[i] = 1 - m_lvl[i];
          m_prs[i] = m_lvl[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("num",      32'(num),      32'(m_ch));
      check("rec_en",   32'(rec_en),   32'(m_mode == 1));
      check("play_en",  32'(play_en),  32'(m_mode == 2));
      check("mem_we",   32'(mem_we),   32'(m_mode == 1 && sample_tick));
      check("mem_rd",   32'(mem_rd),   32'(m_mode == 2 && sample_tick));
      check("mem_addr", 32'(mem_addr), 32'(m_ch * HALF + m_off));
      if (mem_we === 1'b1) wr_log.push_back(mem_addr);
      if (mem_rd === 1'b1) rd_log.push_back(mem_addr);
    end
  end

  task automatic cycle(input logic c, input logic r, input logic p, input logic t);
    btn_chan = c; btn_rec = r; btn_play = p; sample_tick = t;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press(input logic c, input logic r, input logic p);
    repeat (7) cycle(c, r, p, 1'b0);
    idle(7);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [2:0] lv;
    model_reset();
    @(posedge clk);
    #1;
    check("reset_num",  32'(num),      32'd0);
    check("reset_addr", 32'(mem_addr), 32'd0);
    check("reset_rec",  32'(rec_en),   32'd0);
    cmp_en = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(3);

    // Held channel button toggles once; short glitches are filtered.
    repeat (10) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(8);
    check("chan_hold_num", 32'(num), 32'd1);
    repeat (5) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      idle(3);
    end
    idle(6);
    check("glitch_num", 32'(num), 32'd1);

    // Record three samples on channel 1.
    press(1'b0, 1'b1, 1'b0);
    check("rec_started", 32'(rec_en), 32'd1);
    wr_log.delete();
    ticks(3);
    press(1'b0, 1'b1, 1'b0);
    check("rec_stopped", 32'(rec_en), 32'd0);
    check("wr_count", 32'(wr_log.size()), 32'd3);
    check("wr_addr0", 32'(wr_log[0]), 32'd8);
    check("wr_addr2", 32'(wr_log[2]), 32'd10);
    check("model_len1", 32'(m_len[1]), 32'd3);

    // Play them back.
    rd_log.delete();
    press(1'b0, 1'b0, 1'b1);
    check("play_started", 32'(play_en), 32'd1);
    ticks(3);
    check("rd_addr0", 32'(rd_log[0]), 32'd8);
    check("rd_addr2", 32'(rd_log[2]), 32'd10);
`ifdef LOOP_PLAY_EN
    check("loop_still_play", 32'(play_en), 32'd1);
    ticks(1);
    check("loop_rd_wrap", 32'(rd_log[3]), 32'd8);
    press(1'b0, 1'b0, 1'b1);
`endif
    check("play_done", 32'(play_en), 32'd0);

    // Channel 0 is empty: play is refused. Then overfill it.
    press(1'b1, 1'b0, 1'b0);
    check("chan_back_0", 32'(num), 32'd0);
    press(1'b0, 1'b0, 1'b1);
    check("empty_play_refused", 32'(play_en), 32'd0);
    press(1'b0, 1'b1, 1'b0);
    wr_log.delete();
    ticks(9);
    check("full_wr_count", 32'(wr_log.size()), 32'd8);
    check("full_last_addr", 32'(wr_log[7]), 32'd7);
    check("full_auto_stop", 32'(rec_en), 32'd0);
    check("model_len0", 32'(m_len[0]), 32'd8);

    // Coincident chan+rec: rec wins, channel kept. Chan ignored during play.
    press(1'b1, 1'b1, 1'b0);
    check("both_num", 32'(num), 32'd0);
    check("both_rec", 32'(rec_en), 32'd1);
    ticks(2);
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    check("play_ch0", 32'(play_en), 32'd1);
    press(1'b1, 1'b0, 1'b0);
    check("chan_in_play_num", 32'(num), 32'd0);
    check("chan_in_play_en", 32'(play_en), 32'd1);
    press(1'b0, 1'b0, 1'b1);
    check("play_stopped", 32'(play_en), 32'd0);

    // Asynchronous reset mid-record on channel 1 at offset 5.
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    ticks(5);
    check("pre_reset_addr", 32'(mem_addr), 32'd13);
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_num",  32'(num),      32'd0);
    check("async_rst_rec",  32'(rec_en),   32'd0);
    check("async_rst_addr", 32'(mem_addr), 32'd0);
    idle(2);
    rst = 1'b0;
    idle(2);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    check("post_reset_refused", 32'(play_en), 32'd0);

    // Random button activity and sample ticks against the model.
    lv = '0;
    repeat (4000) begin
      for (int i = 0; i < 3; i++) begin
        if (lv[i]) begin
          if ($urandom_range(0, 7) == 0) lv[i] = 1'b0;
        end else if ($urandom_range(0, 19) == 0) begin
          lv[i] = 1'b1;
        end
      end
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1;
        model_reset();
        cycle(lv[0], lv[1], lv[2], 1'b0);
        rst = 1'b0;
      end else begin
        cycle(lv[0], lv[1], lv[2], ($urandom_range(0, 2) == 0));
      end
    end
    idle(4);
    cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
